// File: rtl/rv32_lsu.sv
// RV32 load/store unit in front of a single-read/single-write word BRAM.
// Loads are lane-extracted and extended; sub-word stores use read-modify-write.
module rv32_lsu #(
    parameter int DMEM_AW    = 12,
    parameter int MEM_RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rv32_io_program,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic               resp_err,
    output logic [31:0]        resp_rdata,
    output logic               busy,
    output logic [DMEM_AW-1:0] mem_raddr,
    input  logic [31:0]        mem_rdata,
    output logic [DMEM_AW-1:0] mem_waddr,
    output logic [31:0]        mem_wdata,
    output logic               mem_wen,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [1:0] RD_CNT_INIT = 2'(MEM_RD_LAT - 1);

    state_t             state;
    logic [1:0]         cnt;
    logic               lat_we;
    logic [2:0]         lat_f3;
    logic [1:0]         lat_lane;
    logic [DMEM_AW-1:0] lat_word;
    logic [31:0]        lat_wdata;

    logic               accept;
    logic               req_err;
    logic [31:0]        shifted;
    logic [15:0]        half_sel;
    logic [31:0]        load_data;
    logic [31:0]        merge_data;

    // Handshake: a request transfers on a rising edge where req_valid and req_ready are both high;
    // req_ready is only offered in IDLE outside programming mode and reset.
    assign req_ready = (state == IDLE) & ~rv32_io_program & ~rst;
    assign accept    = req_valid & req_ready;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        req_err = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
            req_err = 1'b1;
        if (req_we && req_funct3[2])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (req_addr[31:DMEM_AW+2] != '0)
            req_err = 1'b1;
    end

    always_comb begin
        shifted  = mem_rdata >> {lat_lane, 3'b000};
        half_sel = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_f3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Only SB/SH ever merge; SW bypasses the read entirely.
    always_comb begin
        merge_data = mem_rdata;
        if (lat_f3[1:0] == 2'b00)
            merge_data[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
        else
            merge_data[{lat_lane[1], 4'b0000} +: 16] = lat_wdata[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_f3     <= '0;
            lat_lane   <= '0;
            lat_word   <= '0;
            lat_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_wen    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_wen    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_f3    <= req_funct3;
                        lat_lane  <= req_addr[1:0];
                        lat_word  <= req_addr[DMEM_AW+1:2];
                        lat_wdata <= req_wdata;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            mem_wen   <= 1'b1;
                            mem_waddr <= req_addr[DMEM_AW+1:2];
                            mem_wdata <= req_wdata;
                            state     <= WR;
                        end else begin
                            mem_raddr <= req_addr[DMEM_AW+1:2];
                            cnt       <= RD_CNT_INIT;
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else if (lat_we) begin
                        mem_wen   <= 1'b1;
                        mem_waddr <= lat_word;
                        mem_wdata <= merge_data;
                        state     <= WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_lsu.sv
// Self-checking bench for rv32_lsu: word-wide BRAM model, reference memory,
// and an expected-response queue checked whenever resp_valid fires.
module tb_rv32_lsu;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          rv32_io_program;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          busy;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          mem_wen;
    logic [1:0]    dbg_state;

    rv32_lsu #(.DMEM_AW(AW), .MEM_RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .rv32_io_program(rv32_io_program),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .busy(busy), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / memory model ----------------
    always #5 clk = ~clk;

    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    assign mem_rdata = mem[mem_raddr];
    always @(posedge clk) if (mem_wen) mem[mem_waddr] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int          lat_q[$];
    int          acc_cyc  = 0;
    int          resp_cnt = 0;
    int          wen_cnt  = 0;
    int          wen_cyc  = 0;
    logic [AW-1:0] wen_addr;
    logic [31:0]   wen_data;

    always @(negedge clk) begin
        if (resp_valid && req_ready)
            check("valid_ready_overlap", 32'd1, 32'd0);
        if (mem_wen) begin
            wen_cnt++;
            wen_cyc  = cyc;
            wen_addr = mem_waddr;
            wen_data = mem_wdata;
        end
        if (!rst && resp_valid) begin
            logic [32:0] e;
            int          l;
            resp_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("resp_rdata", resp_rdata, e[31:0]);
                check("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
                check("resp_latency", 32'(cyc - acc_cyc), 32'(l));
            end
        end
    end

    // ---------------- reference models ----------------
    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(a)*8 +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        case (f3)
            3'b000:  r[int'(a)*8 +: 8] = wd[7:0];
            3'b001:  r[int'(a[1])*16 +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a negedge; returns #1 after the accepting edge.
    task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output int waited);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        waited     = 0;
        #1;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n0);
        int k;
        k = 0;
        while (resp_cnt == n0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (resp_cnt == n0) check("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic err_e, input logic [31:0] data_e,
                          input int lat_e);
        int n0;
        int w;
        n0 = resp_cnt;
        exp_q.push_back({err_e, data_e});
        lat_q.push_back(lat_e);
        @(negedge clk);
        start_req(we, f3, addr, wd, w);
        wait_resp(n0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          w0;
        int          waited;
        int          n0;
        logic [AW-1:0] r0;
        logic [2:0]  f3_tab [0:7];
        logic        we_tab [0:7];

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        mem[4]     = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;
        for (int i = 32; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        rst             = 1'b1;
        rv32_io_program = 1'b0;
        req_valid       = 1'b0;
        req_we          = 1'b0;
        req_funct3      = 3'b000;
        req_addr        = 32'd0;
        req_wdata       = 32'd0;

        #3;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_raddr", 32'(mem_raddr), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Loads from the preloaded word 0x8899AABB
        do_req(1'b0, 3'b000, 32'h11, 32'd0, 1'b0, 32'hFFFFFFAA, 2);
        do_req(1'b0, 3'b100, 32'h11, 32'd0, 1'b0, 32'h000000AA, 2);
        do_req(1'b0, 3'b001, 32'h12, 32'd0, 1'b0, 32'hFFFF8899, 2);
        do_req(1'b0, 3'b101, 32'h12, 32'd0, 1'b0, 32'h00008899, 2);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'h8899AABB, 2);

        // SB read-modify-write
        w0 = wen_cnt;
        do_req(1'b1, 3'b000, 32'h12, 32'h00000055, 1'b0, 32'd0, 3);
        check("sb_wen_count", 32'(wen_cnt - w0), 32'd1);
        check("sb_waddr", 32'(wen_addr), 32'd4);
        check("sb_wdata", wen_data, 32'h8855AABB);
        check("sb_wen_cycle", 32'(wen_cyc - acc_cyc), 32'd2);
        ref_mem[4] = 32'h8855AABB;
        do_req(1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'h8855AABB, 2);

        // Error cases never touch memory
        w0 = wen_cnt;
        r0 = mem_raddr;
        do_req(1'b1, 3'b010, 32'h15,       32'hDEADBEEF, 1'b1, 32'd0, 1);
        do_req(1'b0, 3'b001, 32'h13,       32'd0,        1'b1, 32'd0, 1);
        do_req(1'b0, 3'b010, 32'h00004000, 32'd0,        1'b1, 32'd0, 1);
        do_req(1'b0, 3'b011, 32'h10,       32'd0,        1'b1, 32'd0, 1);
        do_req(1'b1, 3'b100, 32'h20,       32'd0,        1'b1, 32'd0, 1);
        check("err_no_write", 32'(wen_cnt - w0), 32'd0);
        check("err_raddr_kept", 32'(mem_raddr), 32'(r0));

        // Async reset during the WR cycle of an SH
        n0 = resp_cnt;
        @(negedge clk);
        start_req(1'b1, 3'b001, 32'h10, 32'h00001234, waited);
        waited = 0;
        while (!mem_wen && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("sh_reached_wr", {31'd0, mem_wen}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_wen_drop", {31'd0, mem_wen}, 32'd0);
        check("rst_busy_drop", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_abort", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("abort_no_resp", 32'(resp_cnt - n0), 32'd0);
        check("abort_mem_kept", mem[4], 32'h8855AABB);

        // Programming mode blocks accepts; release accepts on the next edge
        @(negedge clk);
        rv32_io_program = 1'b1;
        req_we          = 1'b0;
        req_funct3      = 3'b010;
        req_addr        = 32'h10;
        req_valid       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("prog_ready_low", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            check("prog_no_accept", {31'd0, busy}, 32'd0);
        end
        n0 = resp_cnt;
        exp_q.push_back({1'b0, 32'h8855AABB});
        lat_q.push_back(2);
        rv32_io_program = 1'b0;
        start_req(1'b0, 3'b010, 32'h10, 32'd0, waited);
        check("prog_release_next_edge", 32'(waited), 32'd0);
        wait_resp(n0);

        // Random traffic against the reference memory
        f3_tab = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b010};
        we_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 24; i++) begin
            int          k;
            int          wi;
            logic [1:0]  a;
            logic [31:0] wd;
            logic [31:0] addr;
            k  = $urandom_range(0, 7);
            wi = $urandom_range(32, 63);
            a  = 2'($urandom_range(0, 3));
            wd = $urandom;
            if (f3_tab[k][1:0] == 2'b01) a[0] = 1'b0;
            if (f3_tab[k][1:0] == 2'b10) a = 2'b00;
            addr = {18'd0, 12'(wi), a};
            if (we_tab[k]) begin
                do_req(1'b1, f3_tab[k], addr, wd, 1'b0, 32'd0, (f3_tab[k] == 3'b010) ? 2 : 3);
                ref_mem[wi] = st_model(ref_mem[wi], f3_tab[k], a, wd);
                do_req(1'b0, 3'b010, {addr[31:2], 2'b00}, 32'd0, 1'b0, ref_mem[wi], 2);
            end else begin
                do_req(1'b0, f3_tab[k], addr, 32'd0, 1'b0, ld_model(ref_mem[wi], f3_tab[k], a), 2);
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
